// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
// Round-robin arbiter that lets NREQ requesters share a single register write
// port. Requests are sampled every cycle. The winner's data, source index and
// acknowledge are registered, so a request seen in cycle N is granted in cycle
// N+1. The block stores no request state, so a request that is dropped before
// it is sampled is never granted.
//
// Parameters
//   NREQ   number of requesters (2..16)
//   WIDTH  data width of each requester and of the shared write port
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   req       per-requester write request (level)
//   req_data  requester i data at [i*WIDTH +: WIDTH]
//   wr_stall  register side cannot accept a write this cycle
//   ack       one-hot, single-cycle acknowledge to the winner
//   wr_en     write enable to the register bank
//   wr_data   write data (holds its last granted value while wr_en=0)
//   wr_src    index of the requester whose data is on wr_data
//   wr_cnt    saturating count of granted writes
//             (present only when REG_WRITE_ARBITER_STATS_EN is defined)
//
// Optional feature macro: REG_WRITE_ARBITER_STATS_EN

module reg_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  localparam int SW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic                  wr_stall,
  output logic [NREQ-1:0]       ack,
  output logic                  wr_en,
  output logic [WIDTH-1:0]      wr_data,
  output logic [SW-1:0]         wr_src
`ifdef REG_WRITE_ARBITER_STATS_EN
  ,
  output logic [15:0]           wr_cnt
`endif
);

  // ptr_q is the most recent winner. The search starts one past it, so the
  // reset value NREQ-1 gives requester 0 first priority.
  logic [SW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             wr_en_q, wr_en_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic [SW-1:0]    wr_src_q, wr_src_d;

  logic             win_found;
  logic [SW-1:0]    win_idx;
  logic             grant;

  // Rotating priority search. Walk the offsets 0..NREQ-1 from ptr+1 and keep
  // the first requester found. The modulo keeps NREQ values that are not a
  // power of two correct.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(ptr_q) + 1 + k) % NREQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = SW'(idx);
      end
    end
  end

  // A stall in the arbitration cycle suppresses the grant. It also leaves the
  // pointer where it is, so the same requester wins once the stall clears.
  assign grant = win_found && !wr_stall;

  always_comb begin
    ptr_d     = ptr_q;
    ack_d     = '0;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    wr_src_d  = wr_src_q;
    if (grant) begin
      ptr_d     = win_idx;
      ack_d     = NREQ'(1) << win_idx;
      wr_en_d   = 1'b1;
      wr_data_d = req_data[int'(win_idx)*WIDTH +: WIDTH];
      wr_src_d  = win_idx;
    end
  end

  // Reset has priority over everything, so a grant that was pending from the
  // cycle before reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= SW'(NREQ - 1);
      ack_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wr_src_q  <= '0;
    end else begin
      ptr_q     <= ptr_d;
      ack_q     <= ack_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      wr_src_q  <= wr_src_d;
    end
  end

  assign ack     = ack_q;
  assign wr_en   = wr_en_q;
  assign wr_data = wr_data_q;
  assign wr_src  = wr_src_q;

`ifdef REG_WRITE_ARBITER_STATS_EN
  logic [15:0] wr_cnt_q, wr_cnt_d;

  // Counts on the registered wr_en, so a grant shows up in wr_cnt one cycle
  // after the grant cycle. The count stops at 16'hFFFF and does not wrap.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (wr_en_q && (wr_cnt_q != 16'hFFFF)) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign wr_cnt = wr_cnt_q;
`endif

endmodule
